// File: rtl/img_proc_pkg.sv
// Shared image-processing types and default geometry for the linebuffer / window_gen pair.
package img_proc_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_KERNEL_W   = 3;
    localparam int DEF_RESOLUTION = 512;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2
    } win_state_t;

endpackage

// File: rtl/window_shreg.sv
// KERNEL_W x KERNEL_W window register: shifts left one column per enabled cycle,
// the incoming column lands in c=KERNEL_W-1 with the oldest row at r=0.
module window_shreg #(
    parameter int DATA_W   = 8,
    parameter int KERNEL_W = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           en,
    input  logic [KERNEL_W-1:0][DATA_W-1:0]                col,
    output logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0]  window
);

    // Column shift; the tap order of col is reversed so r=0 is the top (oldest) row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
        end else if (en) begin
            for (int r = 0; r < KERNEL_W; r++) begin
                for (int c = 0; c < KERNEL_W - 1; c++) begin
                    window[r][c] <= window[r][c+1];
                end
                window[r][KERNEL_W-1] <= col[KERNEL_W-1-r];
            end
        end
    end

endmodule

// File: rtl/window_gen.sv
// Assembles KERNEL_W x KERNEL_W windows from the linebuffer column stream and flags
// the ones lying fully inside the frame, with their top-left raster coordinates.
module window_gen
    import img_proc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int KERNEL_W   = DEF_KERNEL_W,
    parameter int RESOLUTION = DEF_RESOLUTION
) (
    input  logic                                           clk_i,
    input  logic                                           srst_i,
    input  logic [KERNEL_W-1:0][DATA_W-1:0]                col_i,
    input  logic                                           col_valid_i,
    input  logic                                           sof_i,
    output logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0]  window_o,
    output logic                                           win_valid_o,
    output logic [$clog2(RESOLUTION)-1:0]                  win_x_o,
    output logic [$clog2(RESOLUTION)-1:0]                  win_y_o,
    output logic                                           frame_done_o
);

    localparam int               CNT_W    = $clog2(RESOLUTION);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RESOLUTION - 1);
    localparam logic [CNT_W-1:0] EDGE_IDX = CNT_W'(KERNEL_W - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    win_state_t       state_r;
    logic [CNT_W-1:0] col_cnt_r;
    logic [CNT_W-1:0] row_cnt_r;
    logic [CNT_W-1:0] cur_x_s;
    logic [CNT_W-1:0] cur_y_s;
    logic [CNT_W-1:0] col_nxt_s;
    logic [CNT_W-1:0] row_nxt_s;
    logic             in_frame_s;
    logic             last_pix_s;

    window_shreg #(
        .DATA_W   (DATA_W),
        .KERNEL_W (KERNEL_W)
    ) u_shreg (
        .clk    (clk_i),
        .rst    (srst_i),
        .en     (col_valid_i),
        .col    (col_i),
        .window (window_o)
    );

    // Position of the column on the bus (sof forces it to the origin) and the position after it.
    always_comb begin
        cur_x_s   = col_cnt_r;
        cur_y_s   = row_cnt_r;
        col_nxt_s = '0;
        row_nxt_s = '0;
        if (sof_i) begin
            cur_x_s = '0;
            cur_y_s = '0;
        end else begin
            cur_x_s = col_cnt_r;
            cur_y_s = row_cnt_r;
        end
        if (cur_x_s == LAST_IDX) begin
            col_nxt_s = '0;
            if (cur_y_s == LAST_IDX) begin
                row_nxt_s = '0;
            end else begin
                row_nxt_s = cur_y_s + ONE;
            end
        end else begin
            col_nxt_s = cur_x_s + ONE;
            row_nxt_s = cur_y_s;
        end
    end

    assign in_frame_s = (cur_x_s >= EDGE_IDX) && (cur_y_s >= EDGE_IDX);
    assign last_pix_s = (cur_x_s == LAST_IDX) && (cur_y_s == LAST_IDX);

    // Raster counters advance only on accepted columns; wrap is by compare.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            col_cnt_r <= '0;
            row_cnt_r <= '0;
        end else if (col_valid_i) begin
            col_cnt_r <= col_nxt_s;
            row_cnt_r <= row_nxt_s;
        end
    end

    // Frame FSM with registered valid, coordinate and frame-done outputs.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_r      <= S_IDLE;
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            win_x_o      <= '0;
            win_y_o      <= '0;
        end else begin
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            if (col_valid_i) begin
                if (sof_i) begin
                    state_r <= S_PRIME;
                end else begin
                    case (state_r)
                        S_IDLE: begin
                            state_r <= S_PRIME;
                        end
                        S_PRIME: begin
                            if ((row_nxt_s >= EDGE_IDX) && !last_pix_s) begin
                                state_r <= S_STREAM;
                            end
                        end
                        S_STREAM: begin
                            if (in_frame_s) begin
                                win_valid_o <= 1'b1;
                                win_x_o     <= cur_x_s - EDGE_IDX;
                                win_y_o     <= cur_y_s - EDGE_IDX;
                            end
                            if (last_pix_s) begin
                                frame_done_o <= 1'b1;
                                state_r      <= S_IDLE;
                            end
                        end
                        default: begin
                            state_r <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
